// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, state type and instruction field positions
package cpu_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 27;
   localparam int RA_HI  = 26;
   localparam int RA_LO  = 23;
   localparam int RB_HI  = 22;
   localparam int RB_LO  = 19;
   localparam int RC_HI  = 18;
   localparam int RC_LO  = 15;
   localparam int C_HI   = 18;
   localparam int C_LO   = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_T3,
      S_T4,
      S_T5,
      S_T6
   } state_t;

   function automatic logic [15:0] reg_sel(input logic [3:0] idx);
      return 16'h0001 << idx;
   endfunction

   function automatic logic [31:0] sext_c(input logic [18:0] c);
      return {{13{c[18]}}, c};
   endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - opcode classification for alu_sequencer
// Immediate opcodes are only recognised when ALU_SEQ_IMM_EN is defined.
module alu_seq_decode
   import cpu_pkg::*;
(
   input  logic [4:0] opcode,
   output logic       legal,
   output logic       is_muldiv,
   output logic       is_unary,
   output logic       is_imm,
   output logic [4:0] alu_ops
);

   always_comb begin
      legal     = 1'b0;
      is_muldiv = 1'b0;
      is_unary  = 1'b0;
      is_imm    = 1'b0;
      alu_ops   = opcode;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: begin
            legal = 1'b1;
         end
         OP_MUL, OP_DIV: begin
            legal     = 1'b1;
            is_muldiv = 1'b1;
         end
         OP_NEG, OP_NOT: begin
            legal    = 1'b1;
            is_unary = 1'b1;
         end
`ifdef ALU_SEQ_IMM_EN
         // immediate forms reuse the register-form ALU operation
         OP_ADDI: begin
            legal   = 1'b1;
            is_imm  = 1'b1;
            alu_ops = OP_ADD;
         end
         OP_ANDI: begin
            legal   = 1'b1;
            is_imm  = 1'b1;
            alu_ops = OP_AND;
         end
         OP_ORI: begin
            legal   = 1'b1;
            is_imm  = 1'b1;
            alu_ops = OP_OR;
         end
`endif
         default: begin
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - T3..T6 control-step sequencer driving register/ALU strobes
// Immediate forms addi/andi/ori with imm_out/imm_value exist only when ALU_SEQ_IMM_EN is defined.
module alu_sequencer
   import cpu_pkg::*;
#(
   parameter logic [4:0] CLR_OPS = 5'b00000
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [31:0] instr,
   input  logic        hold,
   output logic [15:0] Rin,
   output logic [15:0] Rout,
   output logic        RYin,
   output logic        RYout,
   output logic        RZin,
   output logic        RZHIout,
   output logic        RZLOout,
   output logic        HIin,
   output logic        LOin,
   output logic [4:0]  ops,
   output logic        busy,
   output logic        done,
`ifdef ALU_SEQ_IMM_EN
   output logic        illegal,
   output logic        imm_out,
   output logic [31:0] imm_value
`else
   output logic        illegal
`endif
);

   state_t      state_q, state_d;
   logic [31:0] ir_q, ir_d;
   logic [15:0] rin_q, rin_d, rout_q, rout_d;
   logic        ryin_q, ryin_d, ryout_q, ryout_d, rzin_q, rzin_d;
   logic        rzhi_q, rzhi_d, rzlo_q, rzlo_d, hiin_q, hiin_d, loin_q, loin_d;
   logic [4:0]  ops_q, ops_d;
   logic        busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;
   logic        imm_q, imm_d;
   logic [31:0] immv_q, immv_d;

   logic [4:0]  dec_opcode, dec_ops;
   logic        dec_legal, dec_muldiv, dec_unary, dec_imm;

   // In IDLE we classify the incoming word; afterwards the latched one.
   assign dec_opcode = (state_q == S_IDLE) ? instr[OPC_HI:OPC_LO] : ir_q[OPC_HI:OPC_LO];

   alu_seq_decode u_decode (
      .opcode    (dec_opcode),
      .legal     (dec_legal),
      .is_muldiv (dec_muldiv),
      .is_unary  (dec_unary),
      .is_imm    (dec_imm),
      .alu_ops   (dec_ops)
   );

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      rin_d     = rin_q;
      rout_d    = rout_q;
      ryin_d    = ryin_q;
      ryout_d   = ryout_q;
      rzin_d    = rzin_q;
      rzhi_d    = rzhi_q;
      rzlo_d    = rzlo_q;
      hiin_d    = hiin_q;
      loin_d    = loin_q;
      ops_d     = ops_q;
      busy_d    = busy_q;
      done_d    = done_q;
      illegal_d = illegal_q;
      imm_d     = imm_q;
      immv_d    = immv_q;

      if (!hold) begin
         done_d    = 1'b0;
         illegal_d = 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (dec_legal) begin
                     ir_d    = instr;
                     state_d = S_T3;
                  end else begin
                     illegal_d = 1'b1;
                  end
               end
            end
            S_T3: state_d = S_T4;
            S_T4: state_d = S_T5;
            S_T5: begin
               if (dec_muldiv) begin
                  state_d = S_T6;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
            S_T6: begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase

         // Strobes are computed for the state being entered so they leave flops.
         busy_d  = (state_d != S_IDLE);
         rin_d   = '0;
         rout_d  = '0;
         ryin_d  = 1'b0;
         ryout_d = 1'b0;
         rzin_d  = 1'b0;
         rzhi_d  = 1'b0;
         rzlo_d  = 1'b0;
         hiin_d  = 1'b0;
         loin_d  = 1'b0;
         ops_d   = CLR_OPS;
         imm_d   = 1'b0;
         immv_d  = '0;
         case (state_d)
            S_T3: begin
               rout_d = reg_sel(ir_d[RB_HI:RB_LO]);
               ryin_d = 1'b1;
            end
            S_T4: begin
               ryout_d = 1'b1;
               rzin_d  = 1'b1;
               ops_d   = dec_ops;
               if (dec_imm) begin
                  imm_d = 1'b1;
`ifdef ALU_SEQ_IMM_EN
                  immv_d = sext_c(ir_q[C_HI:C_LO]);
`endif
               end else if (dec_unary) begin
                  rout_d = reg_sel(ir_q[RB_HI:RB_LO]);
               end else begin
                  rout_d = reg_sel(ir_q[RC_HI:RC_LO]);
               end
            end
            S_T5: begin
               rzlo_d = 1'b1;
               ops_d  = dec_ops;
               if (dec_muldiv) begin
                  loin_d = 1'b1;
               end else begin
                  rin_d = reg_sel(ir_q[RA_HI:RA_LO]);
               end
            end
            S_T6: begin
               rzhi_d = 1'b1;
               hiin_d = 1'b1;
               ops_d  = dec_ops;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q   <= S_IDLE;
         ir_q      <= '0;
         rin_q     <= '0;
         rout_q    <= '0;
         ryin_q    <= 1'b0;
         ryout_q   <= 1'b0;
         rzin_q    <= 1'b0;
         rzhi_q    <= 1'b0;
         rzlo_q    <= 1'b0;
         hiin_q    <= 1'b0;
         loin_q    <= 1'b0;
         ops_q     <= CLR_OPS;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         imm_q     <= 1'b0;
         immv_q    <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         rin_q     <= rin_d;
         rout_q    <= rout_d;
         ryin_q    <= ryin_d;
         ryout_q   <= ryout_d;
         rzin_q    <= rzin_d;
         rzhi_q    <= rzhi_d;
         rzlo_q    <= rzlo_d;
         hiin_q    <= hiin_d;
         loin_q    <= loin_d;
         ops_q     <= ops_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         imm_q     <= imm_d;
         immv_q    <= immv_d;
      end
   end

   assign Rin     = rin_q;
   assign Rout    = rout_q;
   assign RYin    = ryin_q;
   assign RYout   = ryout_q;
   assign RZin    = rzin_q;
   assign RZHIout = rzhi_q;
   assign RZLOout = rzlo_q;
   assign HIin    = hiin_q;
   assign LOin    = loin_q;
   assign ops     = ops_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign illegal = illegal_q;

`ifdef ALU_SEQ_IMM_EN
   assign imm_out   = imm_q;
   assign imm_value = immv_q;
`else
   logic unused_imm;
   assign unused_imm = ^{ir_q[14:0], imm_q, immv_q};
`endif

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: CLR_OPS, default 5'b00000, ops value driven in IDLE and after reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 clear  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to execute the instruction on instr; sampled only in IDLE.
REQ-005 instr  input  32  instruction: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0].
REQ-006 hold  input  1  freezes the state and all outputs for the cycle.
REQ-007 Rin, Rout  output  16 each  one-hot general-register bus-load and bus-drive strobes (R0..R15).
REQ-008 RYin, RYout, RZin, RZHIout, RZLOout, HIin, LOin  output  1 each  datapath strobes.
REQ-009 ops  output  5  ALU operation code presented to the datapath.
REQ-010 busy, done, illegal  output  1 each  sequencing status.

Function
REQ-011 States: IDLE, T3, T4, T5, T6; one state per clock, advancing only when hold=0.
REQ-012 IDLE with start=1 and a legal opcode SHALL latch instr internally, assert busy and go to T3; instr changes after latching SHALL be ignored.
REQ-013 Legal opcodes: add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011, mul 01111, div 10000, neg 10001, not 10010.
REQ-014 Illegal opcode with start=1 SHALL pulse illegal for one cycle and remain in IDLE.
REQ-015 T3: Rout[Rb]=1, RYin=1.
REQ-016 T4: Rout[Rc]=1 (neg/not: Rout[Rb]=1), RYout=1, RZin=1, ops=latched opcode.
REQ-017 T5: RZLOout=1; mul/div: LOin=1, next T6; otherwise Rin[Ra]=1, next IDLE with done.
REQ-018 T6 (mul/div only): RZHIout=1, HIin=1, next IDLE with done.
REQ-019 done SHALL be a one-cycle pulse on the cycle after the last T-state; busy deasserts in that same cycle.
REQ-020 ops SHALL hold the latched opcode from T4 through the end of the instruction and return to CLR_OPS in IDLE.
REQ-021 All strobes SHALL be registered, glitch-free, and zero in any state not listed for them; at most one Rin and one Rout bit high.
REQ-022 start during busy SHALL be ignored (no queueing); start in the done cycle SHALL be accepted.
REQ-023 hold=1 in a T-state SHALL keep that state's strobes asserted until hold releases.

Reset
REQ-024 clear=0 SHALL asynchronously force IDLE, all strobes 0, ops=CLR_OPS, busy=done=illegal=0, aborting any instruction mid-sequence with no further strobes.

Configuration
REQ-025 ALU_SEQ_IMM_EN defined: opcodes addi 01100, andi 01101, ori 01110 are legal; T4 asserts output imm_out=1 and drives output imm_value[31:0] = sign-extended C instead of Rout[Rc]; ops = add/and/or respectively.
REQ-026 ALU_SEQ_IMM_EN undefined: imm_out and imm_value absent; 01100-01110 are illegal.

Structure
REQ-027 Opcode constants, state encoding type and instruction field positions SHALL live in shared package cpu_pkg.
REQ-028 One sub-module, alu_seq_decode (combinational: opcode -> legal, is_muldiv, is_unary, is_imm, alu_ops), SHALL be instantiated.

Verification
REQ-029 add: instr opcode 00011 Ra=1 Rb=2 Rc=3, start -> T3 Rout[2],RYin; T4 Rout[3],RZin,ops=00011; T5 RZLOout,Rin[1]; done on 4th cycle after start.
REQ-030 mul Rb=4 Rc=5 -> T5 RZLOout+LOin, T6 RZHIout+HIin, no Rin bit set, done 5 cycles after start.
REQ-031 opcode 11111 with start -> illegal pulse one cycle, busy stays 0, all strobes 0.
REQ-032 clear low during T4 of an and -> all strobes drop immediately, state IDLE, no Rin pulse after clear releases.
REQ-033 hold high for 3 cycles in T3 -> Rout[Rb] and RYin stay asserted 4 cycles total; done delayed by 3 cycles; start asserted mid-hold ignored.
REQ-034 With ALU_SEQ_IMM_EN: addi Ra=6 Rb=7 C=19'h7FFFF -> T4 imm_out=1, imm_value=32'hFFFFFFFF, ops=00011, T5 Rin[6].
